// File: rtl/instr_queue.sv
// Decoupling instruction queue between fetch and decode: buffers {pc, instr}
// pairs in order, presents the oldest with R15 (pc + 8), and flushes in one cycle.
module instr_queue #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_valid,
   input  logic [W-1:0]               push_pc,
   input  logic [W-1:0]               push_instr,
   output logic                       push_ready,
   output logic                       pop_valid,
   input  logic                       pop_ready,
   output logic [W-1:0]               pop_pc,
   output logic [W-1:0]               pop_instr,
   output logic [W-1:0]               pop_r15,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  pc_mem    [DEPTH];
   logic [W-1:0]  instr_mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push_fire;
   logic          pop_fire;

   // Handshake outputs depend only on count, so there is no path from fetch/decode inputs.
   assign push_ready = (count != CW'(DEPTH));
   assign pop_valid  = (count != '0);
   assign push_fire  = push_valid && push_ready;
   assign pop_fire   = pop_valid && pop_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_fire)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop_fire)
            rd_ptr <= rd_ptr + PW'(1);
         if (push_fire && !pop_fire)
            count <= count + CW'(1);
         else if (pop_fire && !push_fire)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
         end
      end else if (push_fire && !flush) begin
         pc_mem[wr_ptr]    <= push_pc;
         instr_mem[wr_ptr] <= push_instr;
      end
   end

   // First-word fall-through read; data is zeroed while empty.
   always_comb begin
      pop_pc    = '0;
      pop_instr = '0;
      pop_r15   = '0;
      if (pop_valid) begin
         pop_pc    = pc_mem[rd_ptr];
         pop_instr = instr_mem[rd_ptr];
         pop_r15   = pc_mem[rd_ptr] + W'(8);
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed scenarios plus random traffic, checked
// against a queue-based reference model.
module tb_instr_queue;

   localparam int DEPTH = 4;
   localparam int W     = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          push_valid = 1'b0;
   logic [W-1:0]  push_pc = '0;
   logic [W-1:0]  push_instr = '0;
   logic          push_ready;
   logic          pop_valid;
   logic          pop_ready = 1'b0;
   logic [W-1:0]  pop_pc;
   logic [W-1:0]  pop_instr;
   logic [W-1:0]  pop_r15;
   logic          flush = 1'b0;
   logic [2:0]    count;

   int n_assert = 0;
   int n_fail   = 0;

   logic [W-1:0] m_pc [$];
   logic [W-1:0] m_in [$];

   instr_queue #(.DEPTH(DEPTH), .W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (push_valid),
      .push_pc    (push_pc),
      .push_instr (push_instr),
      .push_ready (push_ready),
      .pop_valid  (pop_valid),
      .pop_ready  (pop_ready),
      .pop_pc     (pop_pc),
      .pop_instr  (pop_instr),
      .pop_r15    (pop_r15),
      .flush      (flush),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [W-1:0] e_pc, e_in, e_r15;
      int n;
      n = m_pc.size();
      e_pc  = (n != 0) ? m_pc[0] : '0;
      e_in  = (n != 0) ? m_in[0] : '0;
      e_r15 = (n != 0) ? W'(m_pc[0] + 32'd8) : '0;
      chk("count",      64'(count),      64'(n));
      chk("pop_valid",  64'(pop_valid),  64'(n != 0));
      chk("push_ready", 64'(push_ready), 64'(n < DEPTH));
      chk("pop_pc",     64'(pop_pc),     64'(e_pc));
      chk("pop_instr",  64'(pop_instr),  64'(e_in));
      chk("pop_r15",    64'(pop_r15),    64'(e_r15));
   endtask

   task automatic cycle(input logic pv, input logic [W-1:0] pc, input logic [W-1:0] ins,
                        input logic pr, input logic fl);
      bit do_push, do_pop;
      push_valid = pv;
      push_pc    = pc;
      push_instr = ins;
      pop_ready  = pr;
      flush      = fl;
      do_push = pv && (m_pc.size() < DEPTH);
      do_pop  = pr && (m_pc.size() > 0);
      @(posedge clk);
      if (fl) begin
         m_pc.delete();
         m_in.delete();
      end else begin
         if (do_pop) begin
            void'(m_pc.pop_front());
            void'(m_in.pop_front());
         end
         if (do_push) begin
            m_pc.push_back(pc);
            m_in.push_back(ins);
         end
      end
      #1;
      check_model();
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_count",      64'(count),      64'(0));
      chk("rst_pop_valid",  64'(pop_valid),  64'(0));
      chk("rst_push_ready", 64'(push_ready), 64'(1));
      chk("rst_pop_pc",     64'(pop_pc),     64'(0));
      chk("rst_pop_r15",    64'(pop_r15),    64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fill with pop stalled, then an ignored fifth push
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 32'(i * 4), 32'hE3A0_0001 + 32'(i), 1'b0, 1'b0);
      chk("fill_count",      64'(count),      64'(4));
      chk("fill_push_ready", 64'(push_ready), 64'(0));
      cycle(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0);
      chk("full_ignore_head", 64'(pop_pc), 64'(32'h4));
      chk("full_ignore_count", 64'(count), 64'(3));

      // Drain remaining in order
      for (int i = 0; i < 3; i++)
         cycle(1'b0, '0, '0, 1'b1, 1'b0);
      chk("drain_count", 64'(count),     64'(0));
      chk("drain_instr", 64'(pop_instr), 64'(0));
      cycle(1'b0, '0, '0, 1'b1, 1'b0);

      // Steady push+pop at count=2, wrapping the pointers
      cycle(1'b1, 32'h40, 32'h1111_0000, 1'b0, 1'b0);
      cycle(1'b1, 32'h44, 32'h1111_0001, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 32'h48 + 32'(4 * i), 32'h1111_0002 + 32'(i), 1'b1, 1'b0);
         chk("steady_count", 64'(count), 64'(2));
      end
      chk("steady_head", 64'(pop_pc), 64'(32'h68));

      // Flush wins over simultaneous push and pop
      cycle(1'b1, 32'h70, 32'h2222_0000, 1'b0, 1'b0);
      cycle(1'b1, 32'h100, 32'h2222_0001, 1'b1, 1'b1);
      chk("flush_count", 64'(count),     64'(0));
      chk("flush_valid", 64'(pop_valid), 64'(0));
      cycle(1'b1, 32'h200, 32'h2222_0002, 1'b0, 1'b0);
      chk("post_flush_pc", 64'(pop_pc), 64'(32'h200));

      // Asynchronous reset between edges
      cycle(1'b1, 32'h204, 32'h2222_0003, 1'b0, 1'b0);
      push_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_count",      64'(count),      64'(0));
      chk("async_pop_valid",  64'(pop_valid),  64'(0));
      chk("async_push_ready", 64'(push_ready), 64'(1));
      m_pc.delete();
      m_in.delete();
      #1 rst_n = 1'b1;

      // R15 wrap
      cycle(1'b1, 32'hFFFF_FFFC, 32'hE1A0_0000, 1'b0, 1'b0);
      chk("r15_wrap", 64'(pop_r15), 64'(32'h4));
      cycle(1'b0, '0, '0, 1'b1, 1'b0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
